// File: rtl/strhw_ctrl_pkg.sv
// Shared types and constants for the Streebog core.
// Provides block/size word types, the stage handshake state, the message
// controller FSM encoding and the two initialisation vectors.
package strhw_common_types;

  localparam int BLOCK_SIZE = 64;

  typedef logic [511:0] uint512;
  typedef logic [6:0]   uint7;

  // Stage progress as reported by strhw_stage
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Message-level controller states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    OUT       = 3'd4
  } ctrl_state_t;

  localparam uint512 IV512 = 512'h0;
  localparam uint512 IV256 = {64{8'h01}};

endpackage

// File: rtl/strhw_ctrl.sv
// Streebog message-level sequencer.
// Accepts 512-bit blocks (valid/ready), seeds h/N/Sigma from the IV on the
// first block of each message, runs every block through strhw_stage via a
// trigger/state handshake, appends the empty finalisation block after a
// full-length last block and presents the 512/256-bit digest.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   blk_valid_i/blk_ready_o      block handshake; blk_data_i, blk_size_i,
//                                blk_last_i, mode256_i qualify the block
//   hash_o/hash_valid_o/hash_ready_i  digest handshake
//   err_o                        one-cycle pulse on an illegal block size
//   stg_*_o                      trigger, block and chaining values to stage
//   stg_*_new_i, stg_state_i     stage results and progress
module strhw_ctrl
  import strhw_common_types::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_data_i,
  input  logic [6:0]   blk_size_i,
  input  logic         blk_last_i,
  input  logic         mode256_i,
  output logic [511:0] hash_o,
  output logic         hash_valid_o,
  input  logic         hash_ready_i,
  output logic         err_o,
  output logic         stg_trg_o,
  output logic [511:0] stg_block_o,
  output logic [6:0]   stg_block_size_o,
  output logic [511:0] stg_sigma_o,
  output logic [511:0] stg_n_o,
  output logic [511:0] stg_h_o,
  input  logic [511:0] stg_sigma_new_i,
  input  logic [511:0] stg_n_new_i,
  input  logic [511:0] stg_h_new_i,
  input  state_t       stg_state_i
);

  localparam uint7 FULL = 7'(BLOCK_SIZE);

  ctrl_state_t state, state_d;
  logic msg_active, mode256, last_q, pad;
  logic accept, reject, res_ok, go_out, go_pad, take;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d     = state;
    blk_ready_o = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;
    res_ok      = 1'b0;
    go_out      = 1'b0;
    go_pad      = 1'b0;
    take        = 1'b0;
    unique case (state)
      IDLE: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) begin
          if (blk_size_i > FULL) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = TRIG;
          end
        end
      end
      TRIG: state_d = WAIT_BUSY;
      // The stage still shows DONE from the previous block until it picks
      // up the new trigger; only BUSY proves this block is in flight.
      WAIT_BUSY: if (stg_state_i == BUSY) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (stg_state_i == DONE) begin
          res_ok = 1'b1;
          if (pad || (stg_block_size_o < FULL)) begin
            go_out  = 1'b1;
            state_d = OUT;
          end else if (last_q) begin
            go_pad  = 1'b1;
            state_d = TRIG;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OUT: begin
        if (hash_ready_i) begin
          take    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      msg_active       <= 1'b0;
      mode256          <= 1'b0;
      last_q           <= 1'b0;
      pad              <= 1'b0;
      err_o            <= 1'b0;
      stg_trg_o        <= 1'b0;
      hash_valid_o     <= 1'b0;
      hash_o           <= '0;
      stg_block_o      <= '0;
      stg_block_size_o <= '0;
      stg_h_o          <= '0;
      stg_n_o          <= '0;
      stg_sigma_o      <= '0;
    end else begin
      stg_trg_o <= (state_d == TRIG);
      err_o     <= reject;
      if (accept) begin
        stg_block_o      <= blk_data_i;
        stg_block_size_o <= blk_size_i;
        // A short block can only be the tail of a message.
        last_q           <= blk_last_i || (blk_size_i < FULL);
        pad              <= 1'b0;
        if (!msg_active) begin
          stg_h_o     <= mode256_i ? IV256 : IV512;
          stg_n_o     <= '0;
          stg_sigma_o <= '0;
          mode256     <= mode256_i;
          msg_active  <= 1'b1;
        end
      end
      if (res_ok) begin
        stg_h_o     <= stg_h_new_i;
        stg_n_o     <= stg_n_new_i;
        stg_sigma_o <= stg_sigma_new_i;
      end
      if (go_out) begin
        hash_valid_o <= 1'b1;
        hash_o       <= mode256 ? {256'h0, stg_h_new_i[511:256]} : stg_h_new_i;
      end
      // Full-length last block: length is a multiple of 64 bytes, so an
      // empty block must follow to finalise the message.
      if (go_pad) begin
        stg_block_o      <= '0;
        stg_block_size_o <= '0;
        pad              <= 1'b1;
      end
      if (take) begin
        hash_valid_o <= 1'b0;
        msg_active   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_strhw_ctrl.sv
// Bench for strhw_ctrl with a behavioural stand-in for strhw_stage.
module tb_strhw_ctrl;
  import strhw_common_types::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid_i = 1'b0;
  logic         blk_ready_o;
  logic [511:0] blk_data_i = '0;
  logic [6:0]   blk_size_i = '0;
  logic         blk_last_i = 1'b0;
  logic         mode256_i = 1'b0;
  logic [511:0] hash_o;
  logic         hash_valid_o;
  logic         hash_ready_i = 1'b0;
  logic         err_o;
  logic         stg_trg_o;
  logic [511:0] stg_block_o;
  logic [6:0]   stg_block_size_o;
  logic [511:0] stg_sigma_o, stg_n_o, stg_h_o;
  logic [511:0] sig_new, n_new, h_new;
  state_t       stg_state;

  always #5 clk = ~clk;

  strhw_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .blk_data_i(blk_data_i), .blk_size_i(blk_size_i), .blk_last_i(blk_last_i),
    .mode256_i(mode256_i),
    .hash_o(hash_o), .hash_valid_o(hash_valid_o), .hash_ready_i(hash_ready_i),
    .err_o(err_o),
    .stg_trg_o(stg_trg_o), .stg_block_o(stg_block_o), .stg_block_size_o(stg_block_size_o),
    .stg_sigma_o(stg_sigma_o), .stg_n_o(stg_n_o), .stg_h_o(stg_h_o),
    .stg_sigma_new_i(sig_new), .stg_n_new_i(n_new), .stg_h_new_i(h_new),
    .stg_state_i(stg_state)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic uint512 stage_h(uint512 h, uint512 n, uint512 s, uint512 b);
    return ({h[510:0], h[511]} ^ b ^ s) + n + 512'd1;
  endfunction

  // Stage stand-in: keeps the old DONE visible for one cycle after a
  // trigger, stays BUSY for 4 cycles, then computes from its held inputs.
  logic pend;
  int   cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_state <= CLEAR;
      pend      <= 1'b0;
      cnt       <= 0;
      h_new     <= '0;
      n_new     <= '0;
      sig_new   <= '0;
    end else if (stg_trg_o) begin
      pend <= 1'b1;
    end else if (pend) begin
      pend      <= 1'b0;
      stg_state <= BUSY;
      cnt       <= 3;
    end else if (stg_state == BUSY) begin
      if (cnt == 0) begin
        stg_state <= DONE;
        h_new     <= stage_h(stg_h_o, stg_n_o, stg_sigma_o, stg_block_o);
        n_new     <= stg_n_o + (512'(stg_block_size_o) << 3);
        sig_new   <= stg_sigma_o + stg_block_o;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Trigger monitor
  int          trg_cnt = 0;
  logic        trg_prev = 1'b0;
  logic [6:0]  last_sz = '0;
  logic [511:0] last_n = '0;
  always @(negedge clk) begin
    if (stg_trg_o) begin
      trg_cnt++;
      last_sz = stg_block_size_o;
      last_n  = stg_n_o;
      n_chk++;
      if (trg_prev) begin
        n_fail++;
        $display("FAIL trg_pulse_width: got 2+ cycles expected 1");
      end
    end
    trg_prev = stg_trg_o;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  typedef struct {
    logic       mode;
    int         nblk;
    int         sz0;
    int         sz1;
    int         exp_trg;
    logic [6:0] exp_last_sz;
    int         exp_last_n;
  } vec_t;

  vec_t tbl[6];

  function automatic uint512 mk_block(int size, int off);
    uint512 b = '0;
    for (int i = 0; i < size; i++) b[8*i +: 8] = 8'h30 + 8'((i + off) % 10);
    return b;
  endfunction

  function automatic uint512 ref_digest(vec_t v);
    uint512 h, n, s, hn;
    uint512 blk[3];
    int     sz[3];
    int     c;
    blk[0] = mk_block(v.sz0, 0); sz[0] = v.sz0; c = 1;
    blk[1] = '0; sz[1] = 0; blk[2] = '0; sz[2] = 0;
    if (v.nblk == 2) begin blk[1] = mk_block(v.sz1, 3); sz[1] = v.sz1; c = 2; end
    if (sz[c-1] == 64) begin blk[c] = '0; sz[c] = 0; c++; end
    h = v.mode ? {64{8'h01}} : 512'h0;
    n = '0;
    s = '0;
    for (int i = 0; i < c; i++) begin
      hn = stage_h(h, n, s, blk[i]);
      n  = n + (512'(sz[i]) << 3);
      s  = s + blk[i];
      h  = hn;
    end
    return v.mode ? {256'h0, h[511:256]} : h;
  endfunction

  task automatic send_blk(input uint512 d, input int sz, input logic last, input logic mode);
    int k = 0;
    while (!blk_ready_o && k < 200) begin @(negedge clk); k++; end
    if (!blk_ready_o) timeout("blk_ready_wait");
    blk_valid_i = 1'b1;
    blk_data_i  = d;
    blk_size_i  = 7'(sz);
    blk_last_i  = last;
    mode256_i   = mode;
    @(negedge clk);
    blk_valid_i = 1'b0;
  endtask

  task automatic wait_hash();
    int k = 0;
    while (!hash_valid_o && k < 200) begin @(negedge clk); k++; end
    if (!hash_valid_o) timeout("hash_valid_wait");
  endtask

  task automatic take_hash();
    hash_ready_i = 1'b1;
    @(negedge clk);
    hash_ready_i = 1'b0;
    chk("hash_valid_drop", 512'(hash_valid_o), 512'd0);
  endtask

  task automatic run_msg(input vec_t v, input string tag);
    int t0 = trg_cnt;
    send_blk(mk_block(v.sz0, 0), v.sz0, v.nblk == 1, v.mode);
    // Second block flips the mode input; it must be ignored mid-message.
    if (v.nblk == 2) send_blk(mk_block(v.sz1, 3), v.sz1, 1'b1, ~v.mode);
    wait_hash();
    chk({tag, "_trg_count"}, 512'(trg_cnt - t0), 512'(v.exp_trg));
    chk({tag, "_last_size"}, 512'(last_sz), 512'(v.exp_last_sz));
    chk({tag, "_last_n"}, last_n, 512'(v.exp_last_n));
    chk({tag, "_hash"}, hash_o, ref_digest(v));
    chk({tag, "_ready_in_out"}, 512'(blk_ready_o), 512'd0);
    take_hash();
  endtask

  initial begin
    logic [511:0] held;
    logic         stable;
    int           t0, k;

    tbl[0] = '{1'b0, 1, 63, 0,  1, 7'd63, 0};
    tbl[1] = '{1'b1, 1, 63, 0,  1, 7'd63, 0};
    tbl[2] = '{1'b0, 2, 64, 64, 3, 7'd0,  1024};
    tbl[3] = '{1'b0, 1, 0,  0,  1, 7'd0,  0};
    tbl[4] = '{1'b1, 2, 64, 10, 2, 7'd10, 512};
    tbl[5] = '{1'b0, 1, 64, 0,  2, 7'd0,  512};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_regs", {stg_trg_o, err_o, hash_valid_o, stg_block_size_o},
        512'd0);
    chk("rst_data", hash_o | stg_block_o | stg_h_o | stg_n_o | stg_sigma_o, 512'd0);
    chk("rst_ready", 512'(blk_ready_o), 512'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_msg(tbl[i], $sformatf("vec%0d", i));

    // Illegal size in IDLE
    t0 = trg_cnt;
    blk_valid_i = 1'b1;
    blk_size_i  = 7'd100;
    blk_data_i  = mk_block(64, 1);
    @(negedge clk);
    blk_valid_i = 1'b0;
    chk("err_pulse", 512'(err_o), 512'd1);
    chk("err_ready", 512'(blk_ready_o), 512'd1);
    @(negedge clk);
    chk("err_clear", 512'(err_o), 512'd0);
    repeat (3) @(negedge clk);
    chk("err_no_trg", 512'(trg_cnt - t0), 512'd0);

    // Digest held while consumer stalls
    send_blk(mk_block(63, 0), 63, 1'b1, 1'b0);
    wait_hash();
    held   = hash_o;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!hash_valid_o || hash_o !== held) stable = 1'b0;
    end
    chk("hold_stable", 512'(stable), 512'd1);
    chk("hold_value", hash_o, ref_digest(tbl[0]));
    take_hash();

    // Reset while a message is mid-flight in WAIT_DONE
    send_blk(mk_block(64, 0), 64, 1'b0, 1'b0);
    send_blk(mk_block(64, 3), 64, 1'b0, 1'b0);
    k = 0;
    while (stg_state != BUSY && k < 200) begin @(negedge clk); k++; end
    if (stg_state != BUSY) timeout("busy_wait");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_regs", {stg_trg_o, err_o, hash_valid_o, stg_block_size_o}, 512'd0);
    chk("arst_data", hash_o | stg_block_o | stg_h_o | stg_n_o | stg_sigma_o, 512'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_msg(tbl[0], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
